// File: rtl/cache_def.sv
// rtl/cache_def.sv - shared defaults, line/request types and FSM states for sa_cache_data
package cache_def;

  localparam int NUM_WAYS_DEF  = 4;
  localparam int NUM_SETS_DEF  = 512;
  localparam int LINE_BITS_DEF = 256;

  localparam int IDX_W_DEF = $clog2(NUM_SETS_DEF);
  localparam int WAY_W_DEF = (NUM_WAYS_DEF > 1) ? $clog2(NUM_WAYS_DEF) : 1;
  localparam int BE_W_DEF  = LINE_BITS_DEF / 8;

  typedef logic [LINE_BITS_DEF-1:0] line_t;

  typedef struct packed {
    logic                 we;
    logic [IDX_W_DEF-1:0] index;
    logic [WAY_W_DEF-1:0] way;
    logic [BE_W_DEF-1:0]  be;
  } req_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/sa_cache_data_if.sv
// rtl/sa_cache_data_if.sv - request/response/clear bundle between a requester and sa_cache_data
interface sa_cache_data_if #(
  parameter int NUM_WAYS  = cache_def::NUM_WAYS_DEF,
  parameter int NUM_SETS  = cache_def::NUM_SETS_DEF,
  parameter int LINE_BITS = cache_def::LINE_BITS_DEF
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [IDX_W-1:0]       req_index;
  logic [WAY_W-1:0]       req_way;
  logic [LINE_BITS/8-1:0] req_be;
  logic [LINE_BITS-1:0]   wdata;
  logic                   rdata_valid;
  logic [LINE_BITS-1:0]   rdata;
  logic                   clear_start;
  logic                   busy;

  modport master (
    output req_valid, req_we, req_index, req_way, req_be, wdata, clear_start,
    input  req_ready, rdata_valid, rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_index, req_way, req_be, wdata, clear_start,
    output req_ready, rdata_valid, rdata, busy
  );
endinterface

// File: rtl/cache_way_ram.sv
// rtl/cache_way_ram.sv - one cache way: NUM_SETS x LINE_BITS, byte-enable write, registered read
module cache_way_ram #(
  parameter int NUM_SETS  = cache_def::NUM_SETS_DEF,
  parameter int LINE_BITS = cache_def::LINE_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic                        re,
  input  logic [$clog2(NUM_SETS)-1:0] addr,
  input  logic [LINE_BITS/8-1:0]      be,
  input  logic [LINE_BITS-1:0]        wdata,
  output logic [LINE_BITS-1:0]        rdata
);

  logic [LINE_BITS-1:0] mem [NUM_SETS];

  // No reset on the array: zeroing is the owner's job through the write port.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LINE_BITS / 8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sa_cache_data.sv
// rtl/sa_cache_data.sv - set-associative cache data array with full-array clear sequencer
module sa_cache_data
  import cache_def::*;
#(
  parameter int NUM_WAYS  = NUM_WAYS_DEF,
  parameter int NUM_SETS  = NUM_SETS_DEF,
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  sa_cache_data_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BE_W  = LINE_BITS / 8;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == IDX_W'(NUM_SETS - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  logic clearing, acc, wr_acc, rd_acc;

  assign clearing      = (state == ST_CLEAR);
  assign bus.busy      = clearing;
  assign bus.req_ready = (state == ST_IDLE);
  assign acc           = bus.req_valid && bus.req_ready;
  assign wr_acc        = acc && bus.req_we;
  assign rd_acc        = acc && !bus.req_we;

  // The clear sequencer borrows the shared write port of every way at once.
  logic [IDX_W-1:0]     ram_addr;
  logic [BE_W-1:0]      ram_be;
  logic [LINE_BITS-1:0] ram_wdata;
  logic [LINE_BITS-1:0] way_dout [NUM_WAYS];

  assign ram_addr  = clearing ? clr_cnt : bus.req_index;
  assign ram_be    = clearing ? {BE_W{1'b1}} : bus.req_be;
  assign ram_wdata = clearing ? '0 : bus.wdata;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic sel;
    assign sel = (bus.req_way == WAY_W'(w));

    cache_way_ram #(
      .NUM_SETS  (NUM_SETS),
      .LINE_BITS (LINE_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (clearing || (wr_acc && sel)),
      .re    (rd_acc && sel),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (way_dout[w])
    );
  end

  logic                 rvalid_q;
  logic [WAY_W-1:0]     way_q;
  logic [LINE_BITS-1:0] hold_q;

  // hold_q captures each result so rdata stays put once rdata_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      way_q    <= '0;
      hold_q   <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc)   way_q  <= bus.req_way;
      if (rvalid_q) hold_q <= way_dout[way_q];
    end
  end

  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rvalid_q ? way_dout[way_q] : hold_q;

endmodule
